// File: rtl/sb_pkg.sv
// ============================================================================
// Module      : sb_pkg
// Description : Shared types and defaults for the store buffer slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sb_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int SB_AW            = 32;
    localparam int SB_DW            = 32;

    typedef struct packed {
        logic [SB_AW-1:0] addr;
        logic [SB_DW-1:0] data;
    } sb_entry_t;

endpackage

`default_nettype wire

// File: rtl/sb_match.sv
// ============================================================================
// Module      : sb_match
// Description : Load-address lookup across buffered stores; youngest match wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_match
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic [DEPTH-1:0]                 i_valid,
    input  logic [AW-1:0]                    i_addr,
    input  logic [DEPTH-1:0][AW-1:0]         i_entry_addr,
    input  logic [DEPTH-1:0][DW-1:0]         i_entry_data,
    input  logic [$clog2(DEPTH)-1:0]         i_head,
    output logic                             o_hit,
    output logic [DW-1:0]                    o_hit_data
);

    localparam int c_PW = $clog2(DEPTH);

    logic [DEPTH-1:0] w_match;
    logic [c_PW-1:0]  w_idx;

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
            assign w_match[g] = i_valid[g] && (i_entry_addr[g] == i_addr);
        end
    endgenerate

    assign o_hit = |w_match;

    // Walk from oldest (head) to youngest so the last match seen overrides.
    always_comb begin
        o_hit_data = '0;
        w_idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_head + c_PW'(i);
            if (w_match[w_idx]) begin
                o_hit_data = i_entry_data[w_idx];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
// Module      : store_buffer
// Description : Posted-write FIFO between MEM stage and Data_Memory; loads win
//               the port. Build option STORE_BUFFER_FWD_EN forwards load hits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int AW    = SB_AW,
    parameter int DW    = SB_DW
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [AW-1:0]              cpu_addr_i,
    input  logic [DW-1:0]              cpu_wdata_i,
    input  logic                       cpu_memWrite_i,
    input  logic                       cpu_memRead_i,
    output logic [DW-1:0]              cpu_rdata_o,
    output logic                       stall_o,
    output logic [AW-1:0]              mem_addr_o,
    output logic [DW-1:0]              mem_wdata_o,
    output logic                       mem_memWrite_o,
    input  logic [DW-1:0]              mem_rdata_i,
    input  logic                       mem_ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [DEPTH-1:0][AW-1:0] r_addr;
    logic [DEPTH-1:0][DW-1:0] r_data;
    logic [c_PW-1:0]          r_head;
    logic [c_PW-1:0]          r_tail;
    logic [c_CW-1:0]          r_count;

    logic [DEPTH-1:0] w_valid;
    logic [c_PW-1:0]  w_rel;
    logic             w_full;
    logic             w_load;
    logic             w_hit;
    logic [DW-1:0]    w_hit_data;
    logic             w_fwd;
    logic             w_hit_stall;
    logic             w_load_mem;
    logic             w_pop;
    logic             w_store_stall;
    logic             w_push;

    // An entry is live when its distance from head is below the count.
    always_comb begin
        w_valid = '0;
        w_rel   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rel      = c_PW'(i) - r_head;
            w_valid[i] = ({1'b0, w_rel} < r_count);
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_match (
        .i_valid      (w_valid),
        .i_addr       (cpu_addr_i),
        .i_entry_addr (r_addr),
        .i_entry_data (r_data),
        .i_head       (r_head),
        .o_hit        (w_hit),
        .o_hit_data   (w_hit_data)
    );

    assign w_full = (r_count == c_CW'(DEPTH));
    assign w_load = cpu_memRead_i & ~cpu_memWrite_i;

`ifdef STORE_BUFFER_FWD_EN
    assign w_fwd       = w_load & w_hit;
    assign w_hit_stall = 1'b0;
`else
    assign w_fwd       = 1'b0;
    assign w_hit_stall = w_load & w_hit;
`endif

    assign w_load_mem = w_load & ~w_hit;

    always_comb begin
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        mem_memWrite_o = 1'b0;
        cpu_rdata_o    = '0;
        if (w_load_mem) begin
            mem_addr_o  = cpu_addr_i;
            cpu_rdata_o = mem_rdata_i;
        end else begin
            if (r_count != '0) begin
                mem_addr_o     = r_addr[r_head];
                mem_wdata_o    = r_data[r_head];
                mem_memWrite_o = 1'b1;
            end
            if (w_fwd) begin
                cpu_rdata_o = w_hit_data;
            end
        end
    end

    assign w_pop         = mem_memWrite_o & mem_ready_i;
    assign w_store_stall = cpu_memWrite_i & w_full & ~w_pop;
    assign w_push        = cpu_memWrite_i & ~w_store_stall;
    assign stall_o       = w_store_stall | w_hit_stall;
    assign count_o       = r_count;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: liveness is tracked by head/count alone.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_addr[r_tail] <= cpu_addr_i;
            r_data[r_tail] <= cpu_wdata_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// Module      : tb_store_buffer
// Description : Directed vector bench for store_buffer with a Data_Memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_wr = 1'b0;
    logic        cpu_rd = 1'b0;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ready = 1'b1;
    logic [2:0]  count;

    logic [31:0] mem [16];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cpu_addr_i     (cpu_addr),
        .cpu_wdata_i    (cpu_wdata),
        .cpu_memWrite_i (cpu_wr),
        .cpu_memRead_i  (cpu_rd),
        .cpu_rdata_o    (cpu_rdata),
        .stall_o        (stall),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_memWrite_o (mem_we),
        .mem_rdata_i    (mem_rdata),
        .mem_ready_i    (mem_ready),
        .count_o        (count)
    );

    assign mem_rdata = mem[mem_addr[3:0]];

    always @(posedge clk) begin
        if (mem_we && mem_ready) mem[mem_addr[3:0]] <= mem_wdata;
    end

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rdy;
        logic        e_stall;
        logic        e_we;
        logic [31:0] e_maddr;
        logic [31:0] e_mwd;
        logic [31:0] e_rdata;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vt [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input logic rdy);
        cpu_wr    = wr;
        cpu_rd    = rd;
        cpu_addr  = a;
        cpu_wdata = d;
        mem_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;

        //          wr rd addr wdata rdy stall we maddr mwd   rdata   cnt
        vt[0]  = '{0, 0, 0,  0,  1, 0, 0, 0, 0,  0,      0};
        vt[1]  = '{1, 0, 0,  10, 0, 0, 0, 0, 0,  0,      0};
        vt[2]  = '{1, 0, 1,  11, 0, 0, 1, 0, 10, 0,      1};
        vt[3]  = '{1, 0, 2,  12, 0, 0, 1, 0, 10, 0,      2};
        vt[4]  = '{1, 0, 3,  13, 0, 0, 1, 0, 10, 0,      3};
        vt[5]  = '{1, 0, 4,  14, 0, 1, 1, 0, 10, 0,      4};
        vt[6]  = '{1, 0, 4,  14, 1, 0, 1, 0, 10, 0,      4};
        vt[7]  = '{0, 0, 0,  0,  0, 0, 1, 1, 11, 0,      4};
        vt[8]  = '{0, 1, 9,  0,  1, 0, 0, 9, 0,  32'h109, 4};
        vt[9]  = '{1, 1, 5,  15, 0, 1, 1, 1, 11, 0,      4};
        vt[10] = '{0, 0, 0,  0,  1, 0, 1, 1, 11, 0,      4};
        vt[11] = '{0, 0, 0,  0,  1, 0, 1, 2, 12, 0,      3};
        vt[12] = '{0, 0, 0,  0,  1, 0, 1, 3, 13, 0,      2};
        vt[13] = '{0, 0, 0,  0,  1, 0, 1, 4, 14, 0,      1};
        vt[14] = '{0, 0, 0,  0,  1, 0, 0, 0, 0,  0,      0};
        vt[15] = '{0, 1, 3,  0,  1, 0, 0, 3, 0,  13,     0};
        vt[16] = '{0, 0, 0,  0,  1, 0, 0, 0, 0,  0,      0};

        // Reset and idle outputs
        drive(0, 0, 0, 0, 1);
        tick();
        tick();
        check("rst count", 32'(count), 0);
        check("rst we", 32'(mem_we), 0);
        check("rst stall", 32'(stall), 0);
        check("rst rdata", cpu_rdata, 0);
        rst = 1'b1;

        // T2 store then drain
        drive(1, 0, 0, 1, 1);
        check("t2 accept stall", 32'(stall), 0);
        check("t2 no same-cycle drain", 32'(mem_we), 0);
        tick();
        drive(0, 0, 0, 0, 1);
        check("t2 drain we", 32'(mem_we), 1);
        check("t2 drain addr", mem_addr, 0);
        check("t2 drain data", mem_wdata, 1);
        tick();
        check("t2 mem[0]", mem[0], 1);
        check("t2 count", 32'(count), 0);

        // T3 full/stall, load priority, both-request, drain order
        for (int i = 0; i < 17; i++) begin
            drive(vt[i].wr, vt[i].rd, vt[i].addr, vt[i].wdata, vt[i].rdy);
            check($sformatf("v%0d stall", i), 32'(stall), 32'(vt[i].e_stall));
            check($sformatf("v%0d we", i), 32'(mem_we), 32'(vt[i].e_we));
            check($sformatf("v%0d maddr", i), mem_addr, vt[i].e_maddr);
            check($sformatf("v%0d mwdata", i), mem_wdata, vt[i].e_mwd);
            check($sformatf("v%0d rdata", i), cpu_rdata, vt[i].e_rdata);
            check($sformatf("v%0d count", i), 32'(count), vt[i].e_cnt);
            tick();
        end
        for (int k = 0; k < 5; k++) check($sformatf("t3 mem[%0d]", k), mem[k], 32'(10 + k));

        // T1 reset with stores pending
        drive(1, 0, 5, 1, 0);
        tick();
        drive(1, 0, 6, 2, 0);
        tick();
        check("t1 pending count", 32'(count), 2);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        tick();
        check("t1 count", 32'(count), 0);
        check("t1 we", 32'(mem_we), 0);
        check("t1 stall", 32'(stall), 0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 1);
        tick();
        check("t1 no drain mem[5]", mem[5], 32'h105);

`ifdef STORE_BUFFER_FWD_EN
        // T4 forward youngest match
        drive(1, 0, 2, 2, 0);
        tick();
        drive(1, 0, 2, 7, 0);
        tick();
        drive(0, 1, 2, 0, 0);
        check("t4 rdata", cpu_rdata, 7);
        check("t4 stall", 32'(stall), 0);
        check("t4 drain addr", mem_addr, 2);
        check("t4 drain data", mem_wdata, 2);
        check("t4 count", 32'(count), 2);
        drive(0, 0, 0, 0, 1);
        tick();
        tick();
        check("t4 drained", 32'(count), 0);
        check("t4 mem[2]", mem[2], 7);
`else
        // T5 stall while a load hits the buffer
        drive(1, 0, 2, 2, 1);
        tick();
        drive(1, 0, 2, 7, 1);
        tick();
        drive(0, 1, 2, 0, 1);
        check("t5 hit stall", 32'(stall), 1);
        check("t5 hit drain we", 32'(mem_we), 1);
        check("t5 hit drain data", mem_wdata, 7);
        for (int k = 0; k < 8; k++) begin
            if (!stall) break;
            tick();
            drive(0, 1, 2, 0, 1);
        end
        check("t5 stall released", 32'(stall), 0);
        check("t5 rdata", cpu_rdata, 7);
        check("t5 count", 32'(count), 0);
        tick();
`endif

        // T6 wrap with store/drain pairs
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, 32'(8 + k), 32'h50 + 32'(k), 1);
            check($sformatf("t6 p%0d stall", k), 32'(stall), 0);
            tick();
            drive(0, 0, 0, 0, 1);
            check($sformatf("t6 p%0d addr", k), mem_addr, 32'(8 + k));
            check($sformatf("t6 p%0d data", k), mem_wdata, 32'h50 + 32'(k));
            check($sformatf("t6 p%0d count", k), 32'(count), 1);
            tick();
        end
        for (int k = 0; k < 6; k++) check($sformatf("t6 mem[%0d]", 8 + k), mem[8 + k], 32'h50 + 32'(k));
        check("t6 final count", 32'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
